mxu_ctrl: RTL
=============

Name: mxu_ctrl

Overview:
Sequencer for the DIM x DIM systolic multiply array.
- Buffers operand matrix A (by rows) and matrix B (by columns) through a valid/ready load port.
- On start, clears the array accumulators, then drives diagonally skewed operands onto the array's west and north edges with an enable.
- Waits for the wavefront to reach the far corner node, then pulses done.
- Sits between the host/DMA load path and the array instance.

Parameters:
DIM, 8, array dimension (rows = columns); >= 2
WIDTH, 4, operand element width in bits
CNT_W, $clog2(3*DIM), width of the internal sequence counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
ld_valid  input  1  load beat valid
ld_ready  output  1  load beat accepted when ld_valid & ld_ready
ld_sel  input  1  0 = A row, 1 = B column
ld_idx  input  $clog2(DIM)  row/column index
ld_data  input  DIM*WIDTH  element k at bits [k*WIDTH +: WIDTH]
start  input  1  begin a multiply
busy  output  1  sequence in progress
err  output  1  one-cycle pulse: start rejected
west  output  DIM*WIDTH  west edge operands, lane i = array row i
north  output  DIM*WIDTH  north edge operands, lane j = array column j
arr_clear  output  1  synchronous accumulator clear to the array
arr_en  output  1  array shift/MAC enable
done  output  1  one-cycle pulse: results valid on the array outputs
perf_cycles  output  32  busy-cycle counter (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE; loaded mask (2*DIM bits) = 0; counter = 0.
  - ld_ready = 1; busy, err, arr_clear, arr_en, done = 0; west, north = 0.
  - Operand buffers are not reset.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - ld_ready = 1.
  - An accepted beat writes buffer[ld_sel][ld_idx] and sets the corresponding mask bit.
  - Rewriting the same index overwrites the buffer entry; the mask bit stays set.
- start in IDLE is checked against the registered mask only; a load in the same cycle is written but not counted.
  - Mask all ones: go to CLEAR.
  - Otherwise: err = 1 for one cycle, stay in IDLE, buffers and mask untouched.
- Outside IDLE:
  - ld_ready = 0; loads are ignored.
  - start is ignored with no err.
- CLEAR: 1 cycle, arr_clear = 1, arr_en = 0; counter t cleared to 0.
- FEED: 2*DIM-1 cycles, t = 0 .. 2*DIM-2, arr_en = 1.
  - west lane i = A[i][t-i] if 0 <= t-i < DIM, else 0.
  - north lane j = B[j][t-j] (column j, element t-j) under the same window, else 0.
- DRAIN: DIM-1 cycles, arr_en = 1, west = north = 0.
- DONE: 1 cycle; done = 1, arr_en = 0; mask cleared to 0; next state IDLE.
- busy = 1 in CLEAR, FEED, DRAIN and DONE.
- Latency: start accepted at edge 0 gives:
  - arr_clear in cycle 1; arr_en in cycles 2 .. 3*DIM-1 (3*DIM-2 cycles).
  - done in cycle 3*DIM; ld_ready high again in cycle 3*DIM+1.
- Reset mid-sequence: immediate return to IDLE, all outputs at reset values, mask cleared; a new full load is required.
- west, north, arr_en and arr_clear are registered outputs with no combinational path from inputs.
- err and done are registered one-cycle pulses.

Optional Feature:
MXU_CTRL_PERF_EN
- Defined:
  - perf_cycles increments on every cycle with busy = 1 and saturates at 32'hFFFF_FFFF.
  - It is reset only by reset and is never cleared by done.
- Not defined: no counter logic is built; perf_cycles is tied to 0.

Test Plan:
- DIM=8. Load A = identity and B[j][k] = j+k (mod 16), then start at cycle 0:
  - arr_clear high in cycle 1 only; arr_en high in cycles 2-23; done in cycle 24; busy high in cycles 1-24.
  - Captured array outputs equal B transposed as required by the array mapping.
- Skew check: at FEED t=3:
  - west lane 0 = A[0][3], lane 3 = A[3][0], lane 4 = 0.
  - north lane 2 = B[2][1].
- Only 15 of 16 rows/columns loaded, then start:
  - err pulses for 1 cycle; busy stays 0; ld_ready stays 1.
  - Loading the last column and starting again runs the full sequence.
- Load beat in the same cycle as start with the mask previously 15/16 full:
  - err pulses and the beat is written.
  - The next start is accepted.
- Mid-FEED (t=5): assert start and a load beat:
  - No err; ld_ready = 0; buffer unchanged.
  - The sequence completes on schedule.
- Reset asserted in DRAIN:
  - arr_en, busy and done drop immediately (asynchronously); ld_ready = 1.
  - start without reloading produces err.
  - With MXU_CTRL_PERF_EN defined, perf_cycles = 0 after reset and 24 after one complete run.

Source files
------------

// File: rtl/mxu_ctrl.sv
// Sequencer for a DIM x DIM systolic multiply array: buffers A rows / B columns, then clears, feeds skewed operands and drains.
// Optional busy-cycle counter enabled by defining MXU_CTRL_PERF_EN.
module mxu_ctrl #(
  parameter int unsigned DIM   = 8,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(3*DIM)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic                   ld_sel,
  input  logic [$clog2(DIM)-1:0] ld_idx,
  input  logic [DIM*WIDTH-1:0]   ld_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   err,
  output logic [DIM*WIDTH-1:0]   west,
  output logic [DIM*WIDTH-1:0]   north,
  output logic                   arr_clear,
  output logic                   arr_en,
  output logic                   done,
  output logic [31:0]            perf_cycles
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIM-1:0]       mask_a_q, mask_a_d, mask_b_q, mask_b_d;
  logic                 err_d, ld_acc_c;
  logic                 ld_ready_q, busy_q, err_q, arr_clear_q, arr_en_q, done_q;
  logic [DIM*WIDTH-1:0] west_q, west_d, north_q, north_d;
  logic [DIM*WIDTH-1:0] a_buf_q [DIM];
  logic [DIM*WIDTH-1:0] b_buf_q [DIM];

  // Next state, counter, load mask and skewed edge operands
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mask_a_d = mask_a_q;
    mask_b_d = mask_b_q;
    err_d    = 1'b0;
    ld_acc_c = 1'b0;
    west_d   = '0;
    north_d  = '0;
    case (state_q)
      S_IDLE: begin
        ld_acc_c = ld_valid;
        if (ld_valid) begin
          if (ld_sel) mask_b_d[ld_idx] = 1'b1;
          else        mask_a_d[ld_idx] = 1'b1;
        end
        // only the registered mask qualifies a start
        if (start) begin
          if (&{mask_a_q, mask_b_q}) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        cnt_d   = '0;
      end
      S_FEED: begin
        if (cnt_q == CNT_W'(2*DIM-2)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(DIM-2)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        mask_a_d = '0;
        mask_b_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // lane i carries element t-i, so element k appears when t == i+k
    if (state_d == S_FEED) begin
      for (int i = 0; i < DIM; i++) begin
        for (int k = 0; k < DIM; k++) begin
          if (cnt_d == CNT_W'(i + k)) begin
            west_d[i*WIDTH +: WIDTH]  = a_buf_q[i][k*WIDTH +: WIDTH];
            north_d[i*WIDTH +: WIDTH] = b_buf_q[i][k*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mask_a_q    <= '0;
      mask_b_q    <= '0;
      ld_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      arr_clear_q <= 1'b0;
      arr_en_q    <= 1'b0;
      done_q      <= 1'b0;
      west_q      <= '0;
      north_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_a_q    <= mask_a_d;
      mask_b_q    <= mask_b_d;
      ld_ready_q  <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      err_q       <= err_d;
      arr_clear_q <= (state_d == S_CLEAR);
      arr_en_q    <= (state_d == S_FEED) || (state_d == S_DRAIN);
      done_q      <= (state_d == S_DONE);
      west_q      <= west_d;
      north_q     <= north_d;
    end
  end

  // Operand buffers hold data only; they need no reset
  always_ff @(posedge clk) begin
    if (ld_acc_c) begin
      if (ld_sel) b_buf_q[ld_idx] <= ld_data;
      else        a_buf_q[ld_idx] <= ld_data;
    end
  end

`ifdef MXU_CTRL_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end
  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

  assign ld_ready  = ld_ready_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign arr_clear = arr_clear_q;
  assign arr_en    = arr_en_q;
  assign done      = done_q;
  assign west      = west_q;
  assign north     = north_q;

endmodule
